// File: rtl/mskaes_128bits_inv_ks_seq.sv
// Masked AES-128 inverse key-schedule sequencer.
// Takes a d-share masked K10 and emits K10, K9, ..., K0, one per handshake.
// Build option: define MSKAES_INV_KS_FWD_EN to accept the master key K0 instead.
// The block then runs the forward schedule to K10 internally before emitting anything.
// Shared layout: byte i at [8*d*i +: 8*d], bit b of a byte at [b*d +: d].

module mskaes_128bits_inv_ks_seq_sbox #(
    parameter int d       = 2,
    parameter int LATENCY = 4
) (
    input  logic                   clk,
    input  logic [8*d-1:0]         sh_in,
    input  logic [4*d*(d-1)-1:0]   rnd0,
    input  logic [4*d*(d-1)-1:0]   rnd1,
    input  logic [8*d*(d-1)-1:0]   rnd2,
    output logic [8*d-1:0]         sh_out
);
    // Random bits used by one masked GF(2^8) multiplication.
    localparam int RB = 4*d*(d-1);

    logic [8*d-1:0] x;
    logic [8*d-1:0] x2;
    logic [8*d-1:0] x3;
    logic [8*d-1:0] x12;
    logic [8*d-1:0] x15;
    logic [8*d-1:0] x240;
    logic [8*d-1:0] x252;
    logic [8*d-1:0] x254;
    logic [8*d-1:0] sb_comb;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Repeated squaring is linear over GF(2), so it is applied to each share independently.
    function automatic logic [8*d-1:0] sq_n(input logic [8*d-1:0] a, input int n);
        logic [8*d-1:0] r;
        r = a;
        for (int k = 0; k < n; k++)
            for (int j = 0; j < d; j++)
                r[8*j +: 8] = gf_mul(r[8*j +: 8], r[8*j +: 8]);
        return r;
    endfunction

    // ISW masked multiplication: the cross products are spread over the shares.
    // Each share pair is protected by one fresh random byte.
    function automatic logic [8*d-1:0] isw_mul(input logic [8*d-1:0] a, input logic [8*d-1:0] b,
                                               input logic [RB-1:0] r);
        logic [7:0]     m [d][d];
        logic [8*d-1:0] c;
        int             k;
        k = 0;
        for (int i = 0; i < d; i++)
            for (int j = 0; j < d; j++)
                m[i][j] = 8'h00;
        for (int i = 0; i < d; i++)
            for (int j = i + 1; j < d; j++) begin
                m[i][j] = r[8*k +: 8];
                m[j][i] = (m[i][j] ^ gf_mul(a[8*i +: 8], b[8*j +: 8])) ^ gf_mul(a[8*j +: 8], b[8*i +: 8]);
                k++;
            end
        for (int i = 0; i < d; i++) begin
            c[8*i +: 8] = gf_mul(a[8*i +: 8], b[8*i +: 8]);
            for (int j = 0; j < d; j++)
                if (j != i) c[8*i +: 8] = c[8*i +: 8] ^ m[i][j];
        end
        return c;
    endfunction

    function automatic logic [7:0] aff_lin(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]};
    endfunction

    // Regroup the bitsliced input so that each share is a contiguous byte.
    always_comb begin
        x = '0;
        for (int j = 0; j < d; j++)
            for (int b = 0; b < 8; b++)
                x[8*j + b] = sh_in[b*d + j];
    end

    // Compute the field inverse as x^254 using four masked multiplications.
    assign x2   = sq_n(x, 1);
    assign x3   = isw_mul(x, x2, rnd0);
    assign x12  = sq_n(x3, 2);
    assign x15  = isw_mul(x12, x3, rnd1);
    assign x240 = sq_n(x15, 4);
    assign x252 = isw_mul(x240, x12, rnd2[RB-1:0]);
    assign x254 = isw_mul(x252, x2, rnd2[2*RB-1:RB]);

    // Apply the affine map to each share; the constant 0x63 goes into share 0 only.
    // The result is then put back into the bitsliced layout.
    always_comb begin
        logic [7:0] t;
        sb_comb = '0;
        for (int j = 0; j < d; j++) begin
            t = aff_lin(x254[8*j +: 8]) ^ ((j == 0) ? 8'h63 : 8'h00);
            for (int b = 0; b < 8; b++)
                sb_comb[b*d + j] = t[b];
        end
    end

    if (LATENCY == 1) begin : g_comb
        assign sh_out = sb_comb;
    end else begin : g_pipe
        logic [8*d-1:0] stage [LATENCY-1];
        // Unreset pipeline. Its result is only looked at on the edge that captures it.
        always_ff @(posedge clk) begin
            stage[0] <= sb_comb;
            for (int i = 1; i < LATENCY - 1; i++)
                stage[i] <= stage[i-1];
        end
        assign sh_out = stage[LATENCY-2];
    end
endmodule

module mskaes_128bits_inv_ks_seq #(
    parameter int d        = 2,
    parameter int LATENCY  = 4,
    parameter int rnd_bus0 = 4*d*(d-1),
    parameter int rnd_bus1 = 4*d*(d-1),
    parameter int rnd_bus2 = 8*d*(d-1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [128*d-1:0]        sh_key_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [128*d-1:0]        sh_key_out,
    output logic [3:0]              out_round,
    output logic                    out_last,
    input  logic [4*rnd_bus0-1:0]   rnd_bus0w,
    input  logic [4*rnd_bus1-1:0]   rnd_bus1w,
    input  logic [4*rnd_bus2-1:0]   rnd_bus2w
);
    localparam int BW = 8*d;
    localparam int WW = 32*d;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

`ifdef MSKAES_INV_KS_FWD_EN
    typedef enum logic [1:0] {IDLE, EMIT, SBOX, FWD} state_t;
`else
    typedef enum logic [1:0] {IDLE, EMIT, SBOX} state_t;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [128*d-1:0] key;
    logic [7:0]      rcon;
    logic [3:0]      round;
    logic [CW-1:0]   cnt;
    logic            cnt_done;

    logic [WW-1:0]   w0, w1, w2, w3;
    logic [WW-1:0]   w3_inv, w2_inv, w1_inv, w0_inv;
    logic [WW-1:0]   src;
    logic [WW-1:0]   sub;
    logic [WW-1:0]   rcon_word;
    logic [128*d-1:0] inv_next;
    logic [7:0]      rcon_inv_next;

    assign cnt_done = (cnt == CW'(LATENCY - 1));

    assign w0 = key[0*WW +: WW];
    assign w1 = key[1*WW +: WW];
    assign w2 = key[2*WW +: WW];
    assign w3 = key[3*WW +: WW];

    assign w3_inv = w3 ^ w2;
    assign w2_inv = w2 ^ w1;
    assign w1_inv = w1 ^ w0;

`ifdef MSKAES_INV_KS_FWD_EN
    assign src = (state == FWD) ? w3 : w3_inv;
`else
    assign src = w3_inv;
`endif

    // The public round constant enters share 0 of byte 0 only.
    always_comb begin
        rcon_word = '0;
        for (int b = 0; b < 8; b++)
            rcon_word[b*d] = rcon[b];
    end

    // Sbox i produces output byte i from source byte (i+1)%4. This implements RotWord.
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        mskaes_128bits_inv_ks_seq_sbox #(.d(d), .LATENCY(LATENCY)) u_sbox (
            .clk   (clk),
            .sh_in (src[BW*((i+1)%4) +: BW]),
            .rnd0  (rnd_bus0w[rnd_bus0*i +: rnd_bus0]),
            .rnd1  (rnd_bus1w[rnd_bus1*i +: rnd_bus1]),
            .rnd2  (rnd_bus2w[rnd_bus2*i +: rnd_bus2]),
            .sh_out(sub[BW*i +: BW])
        );
    end

    assign w0_inv        = w0 ^ sub ^ rcon_word;
    assign inv_next      = {w3_inv, w2_inv, w1_inv, w0_inv};
    assign rcon_inv_next = rcon[0] ? (((rcon ^ 8'h1b) >> 1) | 8'h80) : (rcon >> 1);

`ifdef MSKAES_INV_KS_FWD_EN
    logic [WW-1:0]    f0, f1, f2, f3;
    logic [128*d-1:0] fwd_next;
    logic [7:0]       rcon_fwd_next;

    assign f0            = w0 ^ sub ^ rcon_word;
    assign f1            = w1 ^ f0;
    assign f2            = w2 ^ f1;
    assign f3            = w3 ^ f2;
    assign fwd_next      = {f3, f2, f1, f0};
    assign rcon_fwd_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef MSKAES_INV_KS_FWD_EN
                    state_nxt = FWD;
`else
                    state_nxt = EMIT;
`endif
                end
            end
            EMIT: begin
                if (out_ready) state_nxt = (round == 4'd0) ? IDLE : SBOX;
            end
            SBOX: begin
                if (cnt_done) state_nxt = EMIT;
            end
`ifdef MSKAES_INV_KS_FWD_EN
            FWD: begin
                if (cnt_done && round == 4'd9) state_nxt = EMIT;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode. Outputs are driven only while a key is being offered.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        sh_key_out = '0;
        out_round  = 4'd0;
        out_last   = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            EMIT: begin
                out_valid  = 1'b1;
                sh_key_out = key;
                out_round  = round;
                out_last   = (round == 4'd0);
            end
            default: ;
        endcase
    end

    // Key register, round constant, round index and Sbox wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key   <= '0;
            rcon  <= 8'h36;
            round <= 4'd0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        key <= sh_key_in;
                        cnt <= '0;
`ifdef MSKAES_INV_KS_FWD_EN
                        rcon  <= 8'h01;
                        round <= 4'd0;
`else
                        rcon  <= 8'h36;
                        round <= 4'd10;
`endif
                    end
                end
                EMIT: begin
                    if (out_ready) cnt <= '0;
                end
                SBOX: begin
                    if (cnt_done) begin
                        key   <= inv_next;
                        round <= round - 4'd1;
                        rcon  <= rcon_inv_next;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef MSKAES_INV_KS_FWD_EN
                FWD: begin
                    if (cnt_done) begin
                        key   <= fwd_next;
                        round <= round + 4'd1;
                        rcon  <= (round == 4'd9) ? 8'h36 : rcon_fwd_next;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
